// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer: sweeps all input vectors of a combinational gate and checks its truth table.
// Optional abort ports are enabled by defining SWEEP_ABORT_EN.
module gate_sweep_ctrl #(
    parameter int                 N_IN     = 2,
    parameter int                 SETTLE   = 2,
    parameter logic [2**N_IN-1:0] EXPECTED = 4'b1001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [N_IN-1:0]      gate_in,
    input  logic                 gate_out,
`ifdef SWEEP_ABORT_EN
    input  logic                 abort,
    output logic                 aborted,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 pass,
    output logic [N_IN-1:0]      fail_idx
);

    localparam int W  = 2**N_IN;
    localparam int IW = N_IN + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0]    SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [IW-1:0] IDX_LAST    = IW'(W - 1);

    logic [2:0]      r_state;
    logic [IW-1:0]   r_idx;
    logic [3:0]      r_cnt;
    logic [W-1:0]    r_table;
    logic            r_pass;
    logic [N_IN-1:0] r_fail_idx;

    logic [W-1:0]    w_table_nxt;
    logic [W-1:0]    w_diff;
    logic [N_IN-1:0] w_fail_idx;
    logic            w_busy;
    logic            w_last;

    // Table as it will look after this cycle's sample, so pass/fail_idx
    // can be registered on the same edge as the final bit.
    always_comb begin
        w_table_nxt = r_table;
        w_table_nxt[r_idx[N_IN-1:0]] = gate_out;
    end

    assign w_diff = w_table_nxt ^ EXPECTED;

    always_comb begin
        w_fail_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (w_diff[i]) w_fail_idx = N_IN'(i);
        end
    end

    assign w_busy = (r_state == S_APPLY) || (r_state == S_SETTLE) ||
                    (r_state == S_SAMPLE);
    assign w_last = (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_table    <= '0;
            r_pass     <= 1'b0;
            r_fail_idx <= '0;
`ifdef SWEEP_ABORT_EN
            aborted    <= 1'b0;
`endif
        end else begin
`ifdef SWEEP_ABORT_EN
            aborted <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_APPLY;
                        r_idx      <= '0;
                        r_table    <= '0;
                        r_pass     <= 1'b0;
                        r_fail_idx <= '0;
                    end
                end
                S_APPLY: begin
                    r_cnt   <= '0;
                    r_state <= (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_table <= w_table_nxt;
                    if (w_last) begin
                        r_state    <= S_DONE;
                        r_pass     <= (w_diff == '0);
                        r_fail_idx <= w_fail_idx;
                    end else begin
                        r_idx   <= r_idx + IW'(1);
                        r_state <= S_APPLY;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
`ifdef SWEEP_ABORT_EN
            if (abort && w_busy) begin
                r_state    <= S_IDLE;
                r_pass     <= 1'b0;
                r_fail_idx <= '0;
                aborted    <= 1'b1;
            end
`endif
        end
    end

    assign gate_in   = r_idx[N_IN-1:0];
    assign busy      = w_busy;
    assign done      = (r_state == S_DONE);
    assign table_out = r_table;
    assign pass      = r_pass;
    assign fail_idx  = r_fail_idx;

endmodule
